// File: rtl/pwm_motor_driver.sv
// Two-motor PWM driver: command decode, dead-time on direction change, duty ramp and registered drive.
// Optional feature: define LINE_FOLLOW_EN to steer forward motion from the line detectors.
module pwm_motor_driver #(
  parameter int PWM_W       = 8,
  parameter int RAMP_STEP   = 16,
  parameter int RAMP_DIV    = 4,
  parameter int DEAD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fwd_in,
  input  logic             bwd_in,
  input  logic             left_in,
  input  logic             right_in,
  input  logic             stop_in,
  input  logic [PWM_W-1:0] speed_in,
  input  logic             ld_left,
  input  logic             ld_right,
  output logic [3:0]       m1_out,
  output logic [3:0]       m2_out,
  output logic [2:0]       state,
  output logic [PWM_W-1:0] duty
);

  localparam int PS_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DC_W = $clog2(DEAD_CYCLES + 1);

  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(RAMP_DIV - 1);
  localparam logic [PS_W-1:0]  PS_ONE    = PS_W'(1);
  localparam logic [DC_W-1:0]  DC_LOAD   = DC_W'(DEAD_CYCLES);
  localparam logic [DC_W-1:0]  DC_ONE    = DC_W'(1);
  localparam logic [PWM_W-1:0] PWM_ONE   = PWM_W'(1);
  localparam logic [PWM_W:0]   RAMP_INCR = (PWM_W+1)'(RAMP_STEP);

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_FWD   = 3'd1,
    ST_BWD   = 3'd2,
    ST_LEFT  = 3'd3,
    ST_RIGHT = 3'd4,
    ST_DEAD  = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt, w_req;
  logic [PWM_W-1:0] r_duty, w_duty_nxt;
  logic [PS_W-1:0]  r_presc, w_presc_nxt;
  logic [DC_W-1:0]  r_dead, w_dead_nxt;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W:0]   w_ramp_sum;
  logic [3:0]       w_m1_pat, w_m2_pat;
  logic             w_pwm_on;

  // Request decode in fixed priority order
  always_comb begin
    w_req = ST_STOP;
    if (stop_in) begin
      w_req = ST_STOP;
    end else if (fwd_in) begin
`ifdef LINE_FOLLOW_EN
      if (ld_left) begin
        w_req = ST_RIGHT;
      end else if (ld_right) begin
        w_req = ST_LEFT;
      end else begin
        w_req = ST_FWD;
      end
`else
      w_req = ST_FWD;
`endif
    end else if (bwd_in) begin
      w_req = ST_BWD;
    end else if (right_in) begin
      w_req = ST_RIGHT;
    end else if (left_in) begin
      w_req = ST_LEFT;
    end else begin
      w_req = ST_STOP;
    end
  end

`ifndef LINE_FOLLOW_EN
  logic w_unused_ld;
  assign w_unused_ld = ld_left ^ ld_right;
`endif

  assign w_ramp_sum = {1'b0, r_duty} + RAMP_INCR;

  // Next state, duty ramp, prescaler and dead-time counter
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_presc_nxt = r_presc;
    w_dead_nxt  = r_dead;
    case (r_state)
      ST_STOP: begin
        w_state_nxt = w_req;
        w_duty_nxt  = '0;
        w_presc_nxt = '0;
        w_dead_nxt  = '0;
      end
      ST_FWD, ST_BWD, ST_LEFT, ST_RIGHT: begin
        if (w_req == ST_STOP) begin
          w_state_nxt = ST_STOP;
          w_duty_nxt  = '0;
          w_presc_nxt = '0;
        end else if (w_req != r_state) begin
          w_state_nxt = ST_DEAD;
          w_duty_nxt  = '0;
          w_presc_nxt = '0;
          w_dead_nxt  = DC_LOAD;
        end else if (speed_in < r_duty) begin
          w_duty_nxt = speed_in;
        end else if (r_presc == PS_LAST) begin
          w_presc_nxt = '0;
          // Wide sum so a step past all-ones still saturates at speed_in
          if (w_ramp_sum > {1'b0, speed_in}) begin
            w_duty_nxt = speed_in;
          end else begin
            w_duty_nxt = w_ramp_sum[PWM_W-1:0];
          end
        end else begin
          w_presc_nxt = r_presc + PS_ONE;
        end
      end
      ST_DEAD: begin
        if (w_req == ST_STOP) begin
          w_state_nxt = ST_STOP;
          w_duty_nxt  = '0;
          w_presc_nxt = '0;
          w_dead_nxt  = '0;
        end else if (r_dead <= DC_ONE) begin
          w_state_nxt = w_req;
          w_duty_nxt  = '0;
          w_presc_nxt = '0;
          w_dead_nxt  = '0;
        end else begin
          w_dead_nxt = r_dead - DC_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_STOP;
        w_duty_nxt  = '0;
        w_presc_nxt = '0;
        w_dead_nxt  = '0;
      end
    endcase
  end

  // Bridge patterns per state; STOP, DEAD and undefined codes float both motors
  always_comb begin
    w_m1_pat = 4'b0000;
    w_m2_pat = 4'b0000;
    case (r_state)
      ST_FWD: begin
        w_m1_pat = 4'b0110;
        w_m2_pat = 4'b1001;
      end
      ST_BWD: begin
        w_m1_pat = 4'b1001;
        w_m2_pat = 4'b0110;
      end
      ST_LEFT: begin
        w_m1_pat = 4'b0000;
        w_m2_pat = 4'b1001;
      end
      ST_RIGHT: begin
        w_m1_pat = 4'b0110;
        w_m2_pat = 4'b0000;
      end
      default: begin
        w_m1_pat = 4'b0000;
        w_m2_pat = 4'b0000;
      end
    endcase
  end

  assign w_pwm_on = (r_pwm_cnt < r_duty);

  // State, duty, counters and gated motor outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_STOP;
      r_duty    <= '0;
      r_presc   <= '0;
      r_dead    <= '0;
      r_pwm_cnt <= '0;
      m1_out    <= 4'b0000;
      m2_out    <= 4'b0000;
    end else begin
      r_state   <= w_state_nxt;
      r_duty    <= w_duty_nxt;
      r_presc   <= w_presc_nxt;
      r_dead    <= w_dead_nxt;
      r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
      m1_out    <= w_m1_pat & {4{w_pwm_on}};
      m2_out    <= w_m2_pat & {4{w_pwm_on}};
    end
  end

  assign state = r_state;
  assign duty  = r_duty;

endmodule

// File: doc/pwm_motor_driver.md
PWM_MOTOR_DRIVER -- requirements
Module: pwm_motor_driver

Interface
REQ-001 Parameter PWM_W, default 8, width of duty, speed and PWM counter.
REQ-002 Parameter RAMP_STEP, default 16, duty increment per ramp tick.
REQ-003 Parameter RAMP_DIV, default 4, clocks per ramp tick (at least 1).
REQ-004 Parameter DEAD_CYCLES, default 8, clocks of dead-time on a direction change (at least 1).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 fwd_in, bwd_in, left_in, right_in, stop_in  in  1 each  movement commands from the backend.
REQ-008 speed_in  in  PWM_W  target duty; 0 means no drive.
REQ-009 ld_left, ld_right  in  1 each  line detectors.
REQ-010 m1_out  out  4  left motor bits A0 A1 B0 B1.
REQ-011 m2_out  out  4  right motor bits A0 A1 B0 B1.
REQ-012 state  out  3  current state code.
REQ-013 duty  out  PWM_W  current applied duty.

Function
REQ-014 State codes SHALL be STOP=0, FORWARD=1, BACKWARD=2, LEFT=3, RIGHT=4, DEAD=5.
REQ-015 The requested state SHALL be decoded each cycle in this priority order:
- stop_in gives STOP.
- fwd_in gives RIGHT if ld_left, else LEFT if ld_right, else FORWARD.
- bwd_in gives BACKWARD.
- right_in gives RIGHT.
- left_in gives LEFT.
- no command gives STOP.
REQ-016 STOP to a motion state SHALL be entered on the next edge, with duty starting at 0.
REQ-017 Any request for STOP SHALL enter STOP on the next edge from any state, including DEAD, and duty SHALL clear to 0.
REQ-018 A request for a different motion state while in a motion state SHALL enter DEAD, clear duty to 0, and load a dead counter with DEAD_CYCLES.
REQ-019 DEAD SHALL last exactly DEAD_CYCLES clocks, then enter the request present at that edge; a STOP request during DEAD SHALL follow REQ-017.
REQ-020 An unchanged request SHALL keep the current state without disturbing duty.
REQ-021 In a motion state, a ramp prescaler counting 0..RAMP_DIV-1 SHALL add RAMP_STEP to duty on each wrap, saturating at speed_in.
REQ-022 If speed_in is below duty, duty SHALL drop to speed_in on the next edge.
REQ-023 The prescaler SHALL restart at 0 whenever duty is cleared.
REQ-024 A free-running PWM_W-bit counter SHALL wrap from all-ones to 0; pwm_on SHALL be (counter < duty).
REQ-025 Drive patterns (m1, m2) SHALL be:
- FORWARD 0110, 1001
- BACKWARD 1001, 0110
- LEFT 0000, 1001
- RIGHT 0110, 0000
- STOP and DEAD 0000, 0000
REQ-026 m1_out and m2_out SHALL be registered as pattern AND pwm_on, one clock after state, duty and counter.
REQ-027 Undefined state codes 6 and 7 SHALL drive 0000 on both outputs and go to STOP on the next edge.

Reset
REQ-028 While rst_n=0, state, duty, all counters, m1_out and m2_out SHALL be 0, i.e. STOP.
REQ-029 Reset asserted mid-ramp or mid-DEAD SHALL abort immediately; after release, operation SHALL start from STOP.

Configuration
REQ-030 With LINE_FOLLOW_EN defined, fwd_in SHALL honour ld_left and ld_right as in REQ-015.
REQ-031 Without LINE_FOLLOW_EN, ld_left and ld_right SHALL be ignored, fwd_in SHALL always request FORWARD, and the ports SHALL remain present.

Verification
REQ-032 The bench SHALL cover these directed scenarios with default parameters:
- Reset, then fwd_in=1, speed_in=64: state=1 next edge; duty 16/32/48/64 every 4 clocks, then holds at 64; m1_out=0110 for 64 of every 256 clocks.
- In FORWARD with duty 64, bwd_in=1 only: state=5 and duty=0 for 8 clocks, outputs 0000; then state=2, m1_out pattern 1001, ramp from 0.
- In DEAD, stop_in=1: state=0 next edge, outputs 0000 one clock later.
- fwd_in=1, ld_left=1 with LINE_FOLLOW_EN: state=4, m2_out=0000; without the macro: state=1.
- In FORWARD at duty 128, speed_in changes to 32: duty=32 next edge; speed_in=0 gives outputs 0000 while state stays 1.
- rst_n pulsed low mid-ramp at duty 48: all outputs 0 immediately, state=0 after release.
